fifo_ptr_ctrl: RTL

Parametrised read/write pointer controller for the FIFO family. It replaces a single free-running increment-only pointer with a matched write/read pointer pair: request gating, non-power-of-two depth, phase-bit wrap, occupancy count, threshold flags, flush and error reporting. It sits between the FIFO's producer/consumer handshakes and its dual-port storage array, driving the array addresses and enables.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/fifo_wrap_ptr.sv | 42 ++++
 rtl/fifo_ptr_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO family: pointer sizing, wrap arithmetic
// and the status flag bundle.
package fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

  // A pointer is the address plus one phase bit above it.
  function automatic int unsigned ptr_width(input int unsigned a);
    return a + 1;
  endfunction

  function automatic int unsigned next_addr(input int unsigned addr, input int unsigned depth);
    return (addr == depth - 1) ? 0 : addr + 1;
  endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Single phase-bit pointer that counts 0..DEPTH-1 and toggles its phase on wrap.
module fifo_wrap_ptr
  import fifo_pkg::*;
#(
  parameter int unsigned A     = 4,
  parameter int unsigned DEPTH = 2**A
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      clr_i,
  input  logic                      inc_i,
  output logic [ptr_width(A)-1:0]   ptr_o
);

  logic [A-1:0] addr_q, addr_d;
  logic         phase_q, phase_d;
  logic         at_end;

  assign at_end = (addr_q == A'(DEPTH - 1));

  always_comb begin
    addr_d  = addr_q;
    phase_d = phase_q;
    if (inc_i) begin
      addr_d  = A'(next_addr(32'(addr_q), DEPTH));
      phase_d = phase_q ^ at_end;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i || clr_i) begin
      addr_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      phase_q <= phase_d;
    end
  end

  assign ptr_o = {phase_q, addr_q};

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// Matched write/read pointer controller: request gating, occupancy count,
// registered threshold flags, flush and sticky error reporting.
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned A        = 4,
  parameter int unsigned DEPTH    = 2**A,
  parameter int unsigned AF_LEVEL = DEPTH - 1,
  parameter int unsigned AE_LEVEL = 1
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         flush_i,
  input  logic         wr_req_i,
  input  logic         rd_req_i,
  output logic         wr_en_o,
  output logic         rd_en_o,
  output logic [A-1:0] wr_addr_o,
  output logic [A-1:0] rd_addr_o,
  output logic [A:0]   wr_ptr_o,
  output logic [A:0]   rd_ptr_o,
  output logic [A:0]   count_o,
  output logic         full_o,
  output logic         empty_o,
  output logic         almost_full_o,
  output logic         almost_empty_o,
  output logic         overflow_o,
  output logic         underflow_o
);

  typedef logic [ptr_width(A)-1:0] ptr_t;

  if (DEPTH < 2 || DEPTH > 2**A || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_param_check
    $error("fifo_ptr_ctrl: illegal DEPTH/AF_LEVEL/AE_LEVEL combination");
  end

  function automatic fifo_status_t status_for(input logic [A:0] cnt);
    fifo_status_t s;
    s.full         = (32'(cnt) == DEPTH);
    s.empty        = (cnt == '0);
    s.almost_full  = (32'(cnt) >= AF_LEVEL);
    s.almost_empty = (32'(cnt) <= AE_LEVEL);
    return s;
  endfunction

  ptr_t         wr_ptr, rd_ptr;
  logic         wr_en, rd_en;
  logic [A:0]   count_q, count_d;
  fifo_status_t status_q, status_d;
  logic         overflow_q, overflow_d;
  logic         underflow_q, underflow_d;

  assign wr_en = wr_req_i & ~status_q.full  & ~flush_i;
  assign rd_en = rd_req_i & ~status_q.empty & ~flush_i;

  fifo_wrap_ptr #(.A(A), .DEPTH(DEPTH)) u_wr_ptr (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .clr_i  (flush_i),
    .inc_i  (wr_en),
    .ptr_o  (wr_ptr)
  );

  fifo_wrap_ptr #(.A(A), .DEPTH(DEPTH)) u_rd_ptr (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .clr_i  (flush_i),
    .inc_i  (rd_en),
    .ptr_o  (rd_ptr)
  );

  // Flags are derived from the next count so they line up with the pointers.
  always_comb begin
    count_d = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + {{A{1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{A{1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
    status_d    = status_for(count_d);
    overflow_d  = overflow_q  | (wr_req_i & status_q.full);
    underflow_d = underflow_q | (rd_req_i & status_q.empty);
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i || flush_i) begin
      count_q     <= '0;
      status_q    <= status_for('0);
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      status_q    <= status_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Count-based flags and pointer-based flags must never disagree.
  always_ff @(posedge clk_i) begin
    if (rstn_i) begin
      assert (status_q.full == ((wr_ptr[A-1:0] == rd_ptr[A-1:0]) && (wr_ptr[A] != rd_ptr[A])));
      assert (status_q.full == (32'(count_q) == DEPTH));
      assert (status_q.empty == (wr_ptr == rd_ptr));
      assert (status_q.empty == (count_q == '0));
    end
  end

  assign wr_en_o        = wr_en;
  assign rd_en_o        = rd_en;
  assign wr_ptr_o       = wr_ptr;
  assign rd_ptr_o       = rd_ptr;
  assign wr_addr_o      = wr_ptr[A-1:0];
  assign rd_addr_o      = rd_ptr[A-1:0];
  assign count_o        = count_q;
  assign full_o         = status_q.full;
  assign empty_o        = status_q.empty;
  assign almost_full_o  = status_q.almost_full;
  assign almost_empty_o = status_q.almost_empty;
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

endmodule
